// File: rtl/vedic_mac_accum.sv
// Multiply-accumulate back end for the 4x4 Vedic multiplier: sums LEN products into an ACC_W-bit result.
// Define VEDIC_MAC_SATURATE_EN to clamp on overflow; otherwise the accumulator wraps.
module vedic_mac_accum #(
  parameter int ACC_W = 16,
  parameter int LEN   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clr,
  input  logic [7:0]       prod,
  input  logic             prod_valid,
  output logic             prod_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [7:0] LAST = 8'(LEN - 1);

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc_q, acc_nxt;
  logic [7:0]       count_q, count_nxt;
  logic             ovf_q, ovf_nxt;
  logic [ACC_W:0]   sum;
  logic             accept;

  assign accept = (state == RUN) && prod_valid;
  assign sum    = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, prod};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      acc_q   <= acc_nxt;
      count_q <= count_nxt;
      ovf_q   <= ovf_nxt;
    end
  end

  // clr is applied last so it overrides both start and an accept in the same cycle
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc_q;
    count_nxt = count_q;
    ovf_nxt   = ovf_q;
    case (state)
      IDLE: begin
        if (start) begin
          acc_nxt   = '0;
          count_nxt = '0;
          ovf_nxt   = 1'b0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          count_nxt = count_q + 8'd1;
          ovf_nxt   = ovf_q | sum[ACC_W];
`ifdef VEDIC_MAC_SATURATE_EN
          acc_nxt   = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
          acc_nxt   = sum[ACC_W-1:0];
`endif
          if (count_q == LAST) state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (clr) begin
      state_nxt = IDLE;
      acc_nxt   = '0;
      count_nxt = '0;
      ovf_nxt   = 1'b0;
    end
  end

  assign prod_ready = (state == RUN);
  assign out_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign acc_out    = acc_q;
  assign ovf        = ovf_q;

endmodule

// File: doc/vedic_mac_accum.md
Name: vedic_mac_accum

Overview:
- Sequential multiply-accumulate back end placed directly downstream of the 4x4 Vedic multiplier.
- Consumes the 8-bit product stream `p` through a valid/ready handshake.
- Sums exactly LEN products into an ACC_W-bit accumulator.
- Presents the final sum with an output valid/ready handshake and a sticky overflow flag.

Parameters:
- ACC_W, 16, accumulator/result width in bits; legal range 8..32.
- LEN, 4, number of products summed per run; legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a run when in IDLE.
- clr  input  1  synchronous abort; returns to IDLE, clears accumulator, counter and ovf.
- prod  input  8  product from the multiplier (`p[7:0]`), unsigned.
- prod_valid  input  1  `prod` is valid this cycle.
- prod_ready  output  1  block accepts `prod` this cycle.
- acc_out  output  ACC_W  accumulated sum, registered.
- out_valid  output  1  `acc_out` holds a completed result.
- out_ready  input  1  downstream accepts the result.
- busy  output  1  high in RUN or DONE.
- ovf  output  1  sticky; set when any accumulation exceeds 2^ACC_W-1 during the current run.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; acc_out=0, count=0, ovf=0, out_valid=0, prod_ready=0, busy=0.
- States:
  - IDLE: prod_ready=0. When start=1: acc=0, count=0, ovf=0; next state RUN.
  - RUN: prod_ready=1, busy=1.
    - Accept occurs when prod_valid && prod_ready. On accept: acc <= acc + zero-extended prod, count <= count+1.
    - On the accept that makes count==LEN: next state DONE.
    - prod_valid=0 stalls: no state change.
  - DONE: prod_ready=0, out_valid=1, busy=1; acc_out is stable.
    - When out_ready=1: out_valid drops next cycle and the state returns to IDLE.
    - acc_out and ovf keep their values in IDLE until the next start.
- Latency: out_valid rises on the cycle after the LEN-th accept.
- Minimum run length: LEN+1 cycles from the start cycle to out_valid, given a continuous prod_valid.
- Arithmetic: the sum is computed at ACC_W+1 bits. A carry out of bit ACC_W-1 sets ovf (sticky until the next start, clr or reset).
- Counter: width 8 bits; it never wraps because LEN<=255.
- start outside IDLE is ignored, with no restart.
- clr has priority over start and over an accept in the same cycle. From any state, clr forces IDLE, acc=0, count=0, ovf=0, out_valid=0.
- start and clr in the same cycle in IDLE: clr wins and the state stays IDLE.
- prod_valid in IDLE or DONE: ignored; prod_ready=0, so no accept.
- Reset asserted mid-run: immediate return to reset values; no partial result is reported.

Optional Feature:
- Macro: VEDIC_MAC_SATURATE_EN.
- Defined: on overflow the accumulator clamps to 2^ACC_W-1 and stays there for the rest of the run; ovf is set as before.
- Not defined: the accumulator wraps modulo 2^ACC_W; ovf is still set.
- The handshake, latency and state machine are identical in both builds.

Test Plan:
- Basic run: ACC_W=16, LEN=4; start, then prod=225 (15x15) with prod_valid held for 4 cycles -> out_valid on the cycle after the 4th accept, acc_out=900 (0x0384), ovf=0.
- Gapped input: prod_valid pattern 1,0,0,1,0,1,1 with prod=10,20,30,40 -> 4 accepts only, acc_out=100, no accept while prod_valid=0.
- Output backpressure: hold out_ready=0 for 3 cycles after out_valid -> acc_out and out_valid stable throughout; IDLE the cycle after out_ready=1.
- Overflow: ACC_W=9, LEN=4, prod=225 x4 -> ovf=1. Wrap build: acc_out=388. VEDIC_MAC_SATURATE_EN build: acc_out=511.
- Abort: clr after 2 accepts -> IDLE next cycle, acc_out=0, busy=0. A new start with products 1,2,3,4 -> acc_out=10.
- Async reset: drop rst_n mid-RUN between clock edges -> all outputs 0 immediately. start in DONE is ignored: the result is unchanged.
